// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 for the M stage: SR, Cause, EPC and PRId registers, interrupt/exception
// arbitration, flush/vector request, mfc0/mtc0 service and eret EXL clearing.
module cp0_exception_unit #(
  parameter logic [31:0] PRID       = 32'h4B4E_0007,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        we,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        irq,
  output logic [31:0] vec_pc,
  output logic [31:0] epc,
  output logic [31:0] rd_data
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;

  logic [5:0]  sr_im_nxt;
  logic        sr_exl_nxt;
  logic        sr_ie_nxt;
  logic        cause_bd_nxt;
  logic [4:0]  cause_exc_nxt;
  logic [31:0] epc_nxt;

  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts use the registered IP, giving one cycle of latency from hw_int.
  always_comb begin
    int_req   = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    exc_req   = (|exc_code_m) & ~sr_exl;
    irq       = (int_req | exc_req) & reset;
    victim_pc = bd_m ? (pc_m - 32'd4) : pc_m;
  end

  // Same-edge precedence: exception capture, then mtc0, then eret's EXL clear.
  always_comb begin
    sr_im_nxt     = sr_im;
    sr_exl_nxt    = sr_exl;
    sr_ie_nxt     = sr_ie;
    cause_bd_nxt  = cause_bd;
    cause_exc_nxt = cause_exc;
    epc_nxt       = epc_q;

    if (irq) begin
      sr_exl_nxt    = 1'b1;
      cause_bd_nxt  = bd_m;
      cause_exc_nxt = int_req ? 5'd0 : exc_code_m;
      epc_nxt       = {victim_pc[31:2], 2'b00};
    end else begin
      if (we) begin
        case (wr_addr)
          REG_SR: begin
            sr_im_nxt  = wr_data[15:10];
            sr_exl_nxt = wr_data[1];
            sr_ie_nxt  = wr_data[0];
          end
          REG_EPC: epc_nxt = {wr_data[31:2], 2'b00};
          default: ;
        endcase
      end
      if (exl_clr) begin
        sr_exl_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      sr_im     <= sr_im_nxt;
      sr_exl    <= sr_exl_nxt;
      sr_ie     <= sr_ie_nxt;
      cause_bd  <= cause_bd_nxt;
      cause_ip  <= hw_int;
      cause_exc <= cause_exc_nxt;
      epc_q     <= epc_nxt;
    end
  end

  always_comb begin
    sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
    case (rd_addr)
      REG_SR:    rd_data = sr_word;
      REG_CAUSE: rd_data = cause_word;
      REG_EPC:   rd_data = epc_q;
      REG_PRID:  rd_data = PRID;
      default:   rd_data = 32'd0;
    endcase
  end

  assign vec_pc = EXC_VECTOR;
  assign epc    = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: a table of mtc0/mfc0 vectors followed by
// hand-written interrupt, exception, eret and reset sequences.
module tb_cp0_exception_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        irq;
  logic [31:0] vec_pc;
  logic [31:0] epc;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  cp0_exception_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .irq        (irq),
    .vec_pc     (vec_pc),
    .epc        (epc),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input string name, input logic [4:0] addr, input logic [31:0] expected);
    rd_addr = addr;
    #1;
    check(name, rd_data, expected);
  endtask

  task automatic idle_inputs();
    we         = 1'b0;
    wr_addr    = 5'd0;
    wr_data    = 32'd0;
    exl_clr    = 1'b0;
    exc_code_m = 5'd0;
    bd_m       = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"epc_write_old", 1'b1, 5'd14, 32'h1234_5677, 5'd14, 32'h0000_0000, 1'b0};
    vecs[1] = '{"epc_write_new", 1'b0, 5'd0,  32'h0,         5'd14, 32'h1234_5674, 1'b0};
    vecs[2] = '{"sr_write_old",  1'b1, 5'd12, 32'hFFFF_FFFC, 5'd12, 32'h0000_0000, 1'b0};
    vecs[3] = '{"sr_write_new",  1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_FC00, 1'b0};
    vecs[4] = '{"cause_ro_old",  1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1'b0};
    vecs[5] = '{"cause_ro_new",  1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0000, 1'b0};
    vecs[6] = '{"unimpl_write",  1'b1, 5'd20, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 1'b0};
    vecs[7] = '{"prid_read",     1'b0, 5'd0,  32'h0,         5'd15, 32'h4B4E_0007, 1'b0};
    vecs[8] = '{"sr_clear_old",  1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'h0000_FC00, 1'b0};
    vecs[9] = '{"sr_clear_new",  1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_0000, 1'b0};

    reset   = 1'b0;
    rd_addr = 5'd0;
    pc_m    = 32'd0;
    hw_int  = 6'd0;
    idle_inputs();
    #12;
    reset = 1'b1;
    tick();

    // Reset state
    read_reg("reset_sr", 5'd12, 32'h0);
    read_reg("reset_cause", 5'd13, 32'h0);
    read_reg("reset_epc", 5'd14, 32'h0);
    read_reg("reset_prid", 5'd15, 32'h4B4E_0007);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_epc_port", epc, 32'h0);
    check("vec_pc", vec_pc, 32'h0000_4180);

    // mtc0/mfc0 table: read in the write cycle sees the old value
    for (int i = 0; i < 10; i++) begin
      we      = vecs[i].we;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      rd_addr = vecs[i].rd_addr;
      #1;
      check(vecs[i].name, rd_data, vecs[i].exp_rd);
      check({vecs[i].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      tick();
    end
    idle_inputs();
    check("epc_port_after_table", epc, 32'h1234_5674);

    // Interrupt with one cycle of latency
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
    tick();
    idle_inputs();
    hw_int = 6'b000100;
    pc_m   = 32'h3010;
    #1;
    check("int_latency_irq_low", {31'd0, irq}, 32'd0);
    tick();
    check("int_irq_high", {31'd0, irq}, 32'd1);
    tick();
    check("int_epc", epc, 32'h3010);
    read_reg("int_cause", 5'd13, 32'h0000_1000);
    read_reg("int_sr_exl", 5'd12, 32'h0000_FC03);
    check("int_masked_by_exl", {31'd0, irq}, 32'd0);

    // eret clears EXL; held interrupt fires on the following cycle
    exl_clr = 1'b1;
    #1;
    check("exl_clr_cycle_irq", {31'd0, irq}, 32'd0);
    tick();
    exl_clr = 1'b0;
    read_reg("exl_cleared_sr", 5'd12, 32'h0000_FC01);
    check("held_int_fires", {31'd0, irq}, 32'd1);

    // Interrupt beats concurrent mtc0 and exl_clr
    pc_m = 32'h3040; we = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF; exl_clr = 1'b1;
    tick();
    idle_inputs();
    check("prec_epc", epc, 32'h3040);
    read_reg("prec_sr", 5'd12, 32'h0000_FC03);

    // Synchronous exception in a delay slot
    hw_int  = 6'd0;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    exc_code_m = 5'd12; pc_m = 32'h3024; bd_m = 1'b1;
    #1;
    check("exc_irq", {31'd0, irq}, 32'd1);
    tick();
    check("exc_epc", epc, 32'h3020);
    read_reg("exc_cause", 5'd13, 32'h8000_0030);
    read_reg("exc_sr", 5'd12, 32'h0000_FC03);
    check("exc_masked_by_exl", {31'd0, irq}, 32'd0);

    // Interrupt and exception together: interrupt wins, ExcCode 0
    exc_code_m = 5'd0; bd_m = 1'b0;
    hw_int  = 6'b000001;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    exc_code_m = 5'd4; pc_m = 32'h3050;
    #1;
    check("prio_irq", {31'd0, irq}, 32'd1);
    tick();
    idle_inputs();
    check("prio_epc", epc, 32'h3050);
    read_reg("prio_cause", 5'd13, 32'h0000_0400);

    // Asynchronous reset in the middle of a handler
    #2;
    reset = 1'b0;
    #1;
    check("areset_epc", epc, 32'h0);
    read_reg("areset_sr", 5'd12, 32'h0);
    read_reg("areset_cause", 5'd13, 32'h0);
    check("areset_irq", {31'd0, irq}, 32'd0);
    tick();
    read_reg("areset_hold_cause", 5'd13, 32'h0);
    check("areset_hold_irq", {31'd0, irq}, 32'd0);
    reset  = 1'b1;
    hw_int = 6'd0;
    tick();
    read_reg("post_reset_sr", 5'd12, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
